// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA draw scheduler.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ARM,
        ST_DRAW,
        ST_NEXT,
        ST_WAIT
    } draw_state_t;

    localparam int unsigned DEF_X_W     = 10;
    localparam int unsigned DEF_Y_W     = 9;
    localparam int unsigned DEF_COLOR_W = 9;

    // 3:3:3 colour that the VGA port shows before any client has drawn.
    localparam logic [DEF_COLOR_W-1:0] COLOR_BLACK = 9'h000;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_refresh_timer.sv
// Free-running refresh counter; tick marks the last cycle of each period.
module draw_refresh_timer
    import draw_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = idx_width(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Wrap back to zero after the last count of the period.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
            count_d = '0;
        end
    end

    // Counter register, restarted only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/draw_scheduler.sv
// Time-shares the VGA pixel-write port among drawer clients, one sweep per refresh.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS    = 4,
    parameter  int unsigned X_W            = DEF_X_W,
    parameter  int unsigned Y_W            = DEF_Y_W,
    parameter  int unsigned COLOR_W        = DEF_COLOR_W,
    parameter  int unsigned REFRESH_CYCLES = 833333,
    parameter  int unsigned TIMEOUT_CYCLES = 65536,
    localparam int unsigned IDX_W          = idx_width(NUM_CLIENTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    output logic [NUM_CLIENTS-1:0]         client_start,
    input  logic [NUM_CLIENTS-1:0]         client_done,
    input  logic [NUM_CLIENTS*X_W-1:0]     client_x,
    input  logic [NUM_CLIENTS*Y_W-1:0]     client_y,
    input  logic [NUM_CLIENTS*COLOR_W-1:0] client_color,
    output logic [X_W-1:0]                 vga_x,
    output logic [Y_W-1:0]                 vga_y,
    output logic [COLOR_W-1:0]             vga_color,
    output logic                           vga_plot,
    output logic [IDX_W-1:0]               active_client,
    output logic                           sweep_done,
    output logic [NUM_CLIENTS-1:0]         timeout_err
);

    localparam int unsigned TO_W = idx_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

    draw_state_t            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TO_W-1:0]        draw_cnt_q, draw_cnt_d;
    logic                   enable_q;
    logic [X_W-1:0]         vga_x_q, vga_x_d;
    logic [Y_W-1:0]         vga_y_q, vga_y_d;
    logic [COLOR_W-1:0]     vga_color_q, vga_color_d;
    logic                   plot_q, plot_d;
    logic                   sweep_done_q, sweep_done_d;
    logic [NUM_CLIENTS-1:0] timeout_err_q, timeout_err_d;
    logic                   tick;

    draw_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // Sequencing FSM: next state, port forwarding and status pulses.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        draw_cnt_d    = draw_cnt_q;
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_color_d   = vga_color_q;
        plot_d        = 1'b0;
        sweep_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        client_start  = '0;

        case (state_q)
            ST_IDLE: begin
                // A fresh enable starts at once; otherwise wait for the refresh tick.
                if (enable && (tick || !enable_q)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                client_start[idx_q] = 1'b1;
                draw_cnt_d          = '0;
                state_d             = ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (client_done[idx_q]) begin
                    state_d = ST_NEXT;
                end else if (draw_cnt_q == TO_LAST) begin
                    timeout_err_d[idx_q] = 1'b1;
                    state_d              = ST_NEXT;
                end else begin
                    vga_x_d     = client_x[idx_q*X_W +: X_W];
                    vga_y_d     = client_y[idx_q*Y_W +: Y_W];
                    vga_color_d = client_color[idx_q*COLOR_W +: COLOR_W];
                    plot_d      = 1'b1;
                    draw_cnt_d  = draw_cnt_q + TO_W'(1);
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    sweep_done_d = 1'b1;
                    idx_d        = '0;
                    state_d      = enable ? ST_WAIT : ST_IDLE;
                end else if (!enable) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_START;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            draw_cnt_q    <= '0;
            enable_q      <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_color_q   <= COLOR_W'(COLOR_BLACK);
            plot_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            timeout_err_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            draw_cnt_q    <= draw_cnt_d;
            enable_q      <= enable;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_color_q   <= vga_color_d;
            plot_q        <= plot_d;
            sweep_done_q  <= sweep_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_color     = vga_color_q;
    assign vga_plot      = plot_q;
    assign active_client = idx_q;
    assign sweep_done    = sweep_done_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with stub drawer clients.
module tb_draw_scheduler;

    localparam int N       = 4;
    localparam int XW      = 10;
    localparam int YW      = 9;
    localparam int CW      = 9;
    localparam int REFRESH = 2000;
    localparam int TIMEOUT = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    client_start;
    logic [N-1:0]    client_done;
    logic [N*XW-1:0] client_x;
    logic [N*YW-1:0] client_y;
    logic [N*CW-1:0] client_color;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_color;
    logic            vga_plot;
    logic [1:0]      active_client;
    logic            sweep_done;
    logic [N-1:0]    timeout_err;

    draw_scheduler #(
        .NUM_CLIENTS   (N),
        .X_W           (XW),
        .Y_W           (YW),
        .COLOR_W       (CW),
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .client_start (client_start),
        .client_done  (client_done),
        .client_x     (client_x),
        .client_y     (client_y),
        .client_color (client_color),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_color    (vga_color),
        .vga_plot     (vga_plot),
        .active_client(active_client),
        .sweep_done   (sweep_done),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    // Stub clients: count from their start pulse and raise done after len pixels.
    logic [15:0] stubCnt [N];
    logic [15:0] stubLen [N];
    logic [N-1:0] stubDone;
    logic [N-1:0] forceDone;

    always @(posedge clock) begin
        if (reset) begin
            stubDone <= '0;
            for (int i = 0; i < N; i++) stubCnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (client_start[i]) begin
                    stubCnt[i]  <= '0;
                    stubDone[i] <= 1'b0;
                end else if (!stubDone[i]) begin
                    if (stubCnt[i] == stubLen[i]) stubDone[i] <= 1'b1;
                    else stubCnt[i] <= stubCnt[i] + 16'd1;
                end
            end
        end
    end

    // Client 1 emits (300,150,1C0) on its first pixel; others a simple ramp.
    always_comb begin
        client_x     = '0;
        client_y     = '0;
        client_color = '0;
        for (int i = 0; i < N; i++) begin
            if (i == 1) begin
                client_x[i*XW +: XW]     = XW'(299 + int'(stubCnt[i]));
                client_y[i*YW +: YW]     = YW'(149 + int'(stubCnt[i]));
                client_color[i*CW +: CW] = CW'(9'h1BF + int'(stubCnt[i]));
            end else begin
                client_x[i*XW +: XW]     = XW'(100 * i + int'(stubCnt[i]));
                client_y[i*YW +: YW]     = YW'(10 * i + int'(stubCnt[i]));
                client_color[i*CW +: CW] = CW'(64 * i + int'(stubCnt[i]));
            end
        end
    end

    assign client_done = stubDone | forceDone;

    // Cycle count aligned with the refresh counter.
    int cyc;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Observation of plots, sweeps and start order.
    int plotCnt, sweepCnt, startCnt, lastStart0;
    int startsPer [N];
    logic [7:0] order;

    always @(negedge clock) begin
        if (vga_plot) plotCnt++;
        if (sweep_done) sweepCnt++;
        for (int i = 0; i < N; i++) begin
            if (client_start[i]) begin
                startsPer[i]++;
                startCnt++;
                order = {order[5:0], 2'(i)};
                if (i == 0) lastStart0 = cyc;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] lens, input logic [N-1:0] fd, input logic en);
        for (int i = 0; i < N; i++) stubLen[i] = lens[i*16 +: 16];
        forceDone = fd;
        enable    = en;
    endtask

    task automatic clearMonitor();
        plotCnt  = 0;
        sweepCnt = 0;
        startCnt = 0;
        order    = '0;
        for (int i = 0; i < N; i++) startsPer[i] = 0;
    endtask

    task automatic waitStart(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (client_start[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL wait start%0d: got none want pulse within %0d cycles", idx, budget);
        end
    endtask

    task automatic waitSweep(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (sweep_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL wait sweep_done: got none want pulse within %0d cycles", budget);
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic [63:0] lens;
        int          expPlots;
        logic [3:0]  expErr;
    } vec_t;

    localparam logic [15:0] NEVER = 16'hFFFF;
    localparam logic [63:0] ALL10 = {16'd10, 16'd10, 16'd10, 16'd10};

    initial begin
        vec_t vecs [4];
        bit   ok;
        int   prevStart;

        // lens packs client 0 in the low 16 bits.
        vecs[0] = '{lens: ALL10,                                 expPlots: 40, expErr: 4'b0000};
        vecs[1] = '{lens: {16'd1, 16'd5, 16'd0, 16'd3},          expPlots: 9,  expErr: 4'b0000};
        vecs[2] = '{lens: {16'd10, NEVER, 16'd10, 16'd10},       expPlots: 93, expErr: 4'b0100};
        vecs[3] = '{lens: {16'd2, 16'd2, 16'd2, 16'd2},          expPlots: 8,  expErr: 4'b0100};

        prevStart = 0;
        applyStimulus(ALL10, '0, 1'b0);
        clearMonitor();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        checkOutput("reset vga_plot", 32'(vga_plot), 0);
        checkOutput("reset vga_x", 32'(vga_x), 0);
        checkOutput("reset vga_color", 32'(vga_color), 0);
        checkOutput("reset client_start", 32'(client_start), 0);
        checkOutput("reset sweep_done", 32'(sweep_done), 0);
        checkOutput("reset timeout_err", 32'(timeout_err), 0);
        checkOutput("reset active_client", 32'(active_client), 0);

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].lens, '0, 1'b1);
            clearMonitor();
            waitSweep(2600, ok);
            checkOutput($sformatf("v%0d plots", v), 32'(plotCnt), 32'(vecs[v].expPlots));
            checkOutput($sformatf("v%0d starts", v), 32'(startCnt), 4);
            checkOutput($sformatf("v%0d order", v), 32'(order), 32'h1B);
            checkOutput($sformatf("v%0d sweep_done", v), 32'(sweepCnt), 1);
            checkOutput($sformatf("v%0d timeout_err", v), 32'(timeout_err), 32'(vecs[v].expErr));
            if (v >= 2) checkOutput($sformatf("v%0d interval", v), 32'(lastStart0 - prevStart), REFRESH);
            prevStart = lastStart0;
        end

        // One-cycle forwarding latency on client 1.
        applyStimulus(ALL10, '0, 1'b1);
        waitStart(1, 2600, ok);
        @(negedge clock);
        @(negedge clock);
        checkOutput("lat plot in first draw", 32'(vga_plot), 0);
        @(negedge clock);
        checkOutput("lat vga_x", 32'(vga_x), 300);
        checkOutput("lat vga_y", 32'(vga_y), 150);
        checkOutput("lat vga_color", 32'(vga_color), 32'h1C0);
        checkOutput("lat vga_plot", 32'(vga_plot), 1);
        checkOutput("lat active_client", 32'(active_client), 1);
        waitSweep(600, ok);

        // Stale done on client 0 is ignored in ARM and honoured in DRAW.
        applyStimulus(ALL10, 4'b0001, 1'b1);
        waitStart(0, 2600, ok);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            checkOutput($sformatf("stale plot t+%0d", k), 32'(vga_plot), 0);
        end
        checkOutput("stale start in NEXT", 32'(client_start), 0);
        @(negedge clock);
        checkOutput("stale next start", 32'(client_start), 32'b0010);
        applyStimulus(ALL10, '0, 1'b1);
        waitSweep(600, ok);

        // Enable drops while client 1 draws.
        clearMonitor();
        waitStart(1, 2600, ok);
        enable = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("drop client2 starts", 32'(startsPer[2]), 0);
        checkOutput("drop plots", 32'(plotCnt), 20);
        checkOutput("drop sweep_done", 32'(sweepCnt), 0);
        checkOutput("drop active_client", 32'(active_client), 0);
        checkOutput("drop vga_plot", 32'(vga_plot), 0);

        // Reset while client 0 is plotting.
        applyStimulus(ALL10, '0, 1'b1);
        waitStart(0, 20, ok);
        repeat (3) @(negedge clock);
        checkOutput("pre-reset vga_plot", 32'(vga_plot), 1);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        checkOutput("rst vga_plot", 32'(vga_plot), 0);
        checkOutput("rst vga_x", 32'(vga_x), 0);
        checkOutput("rst vga_y", 32'(vga_y), 0);
        checkOutput("rst vga_color", 32'(vga_color), 0);
        checkOutput("rst client_start", 32'(client_start), 0);
        checkOutput("rst timeout_err", 32'(timeout_err), 0);
        checkOutput("rst active_client", 32'(active_client), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
